// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchronizer, debounce filter,
// mode-qualified one-cycle edge pulse, sticky flag and saturating event counter.
module multi_edge_detector #(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYC     = 3,
   parameter int unsigned CNT_W       = 8,
   localparam int unsigned SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH-1:0]        sig_in,
   input  logic [2*CH-1:0]      mode,
   input  logic [CH-1:0]        clr,
   input  logic [SEL_W-1:0]     cnt_sel,
   output logic [CH-1:0]        level_out,
   output logic [CH-1:0]        pulse_out,
   output logic [CH-1:0]        sticky,
   output logic                 any_event,
   output logic [CNT_W-1:0]     cnt_out
);

   localparam int unsigned DEB_W = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

   logic [CH-1:0]    sync_q [SYNC_STAGES];
   logic [DEB_W-1:0] deb_q  [CH];
   logic [CNT_W-1:0] cnt_q  [CH];

   logic [CH-1:0]    sync_c;
   logic [CH-1:0]    diff_c;
   logic [CH-1:0]    upd_c;
   logic [CH-1:0]    qual_c;

   // Synchronizer chain; the last stage is the channel's sampled value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= sig_in;
         for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Update detection and mode qualification, sampled at the update edge
   always_comb begin
      sync_c = sync_q[SYNC_STAGES-1];
      diff_c = '0;
      upd_c  = '0;
      qual_c = '0;
      for (int i = 0; i < int'(CH); i++) begin
         diff_c[i] = sync_c[i] ^ level_out[i];
         upd_c[i]  = diff_c[i] && (deb_q[i] == DEB_W'(DEB_CYC));
         qual_c[i] = upd_c[i] && ((sync_c[i] && mode[2*i]) || (!sync_c[i] && mode[2*i+1]));
      end
   end

   // Debounce counters and filtered level
   always_ff @(posedge clk) begin
      if (rst) begin
         level_out <= '0;
         for (int i = 0; i < int'(CH); i++) deb_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(CH); i++) begin
            if (!diff_c[i]) begin
               deb_q[i] <= '0;
            end else if (upd_c[i]) begin
               deb_q[i]     <= '0;
               level_out[i] <= sync_c[i];
            end else begin
               deb_q[i] <= deb_q[i] + DEB_W'(1);
            end
         end
      end
   end

   // Qualified-edge pulse, aligned with the level update
   always_ff @(posedge clk) begin
      if (rst) pulse_out <= '0;
      else     pulse_out <= qual_c;
   end

   // Sticky flags: an event in the same cycle as clr wins
   always_ff @(posedge clk) begin
      if (rst) sticky <= '0;
      else     sticky <= qual_c | (sticky & ~clr);
   end

   // Saturating event counters; clr together with an event leaves a count of one
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(CH); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(CH); i++) begin
            if (clr[i])
               cnt_q[i] <= qual_c[i] ? CNT_W'(1) : '0;
            else if (qual_c[i] && (cnt_q[i] != {CNT_W{1'b1}}))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Combinational summary outputs
   always_comb begin
      any_event = |pulse_out;
      cnt_out   = '0;
      if (32'(cnt_sel) < CH) cnt_out = cnt_q[cnt_sel];
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector at default parameters.
module tb_multi_edge_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig_in;
   logic [7:0] mode;
   logic [3:0] clr;
   logic [1:0] cnt_sel;
   logic [3:0] level_out;
   logic [3:0] pulse_out;
   logic [3:0] sticky;
   logic       any_event;
   logic [7:0] cnt_out;

   int checks = 0;
   int errors = 0;

   multi_edge_detector dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .mode      (mode),
      .clr       (clr),
      .cnt_sel   (cnt_sel),
      .level_out (level_out),
      .pulse_out (pulse_out),
      .sticky    (sticky),
      .any_event (any_event),
      .cnt_out   (cnt_out)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle just past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] seen;
      int         npulse;
      int         first_c;
      int         second_c;
      logic [3:0] exp_lvl;

      rst = 1'b1; sig_in = '0; mode = '0; clr = '0; cnt_sel = '0;
      step(2);
      chk("rst_level",  32'(level_out), 32'h0);
      chk("rst_pulse",  32'(pulse_out), 32'h0);
      chk("rst_sticky", 32'(sticky),    32'h0);
      chk("rst_any",    32'(any_event), 32'h0);
      chk("rst_cnt",    32'(cnt_out),   32'h0);
      rst = 1'b0;

      // Channel 0 rising, mode 01: pulse exactly at edge 6
      mode = 8'h01; sig_in = 4'b0001;
      step(5);
      chk("c0_pre_pulse", 32'(pulse_out[0]), 32'h0);
      chk("c0_pre_level", 32'(level_out[0]), 32'h0);
      step(1);
      chk("c0_pulse",  32'(pulse_out[0]), 32'h1);
      chk("c0_level",  32'(level_out[0]), 32'h1);
      chk("c0_any",    32'(any_event),    32'h1);
      chk("c0_sticky", 32'(sticky[0]),    32'h1);
      chk("c0_cnt",    32'(cnt_out),      32'h1);
      step(1);
      chk("c0_pulse_end", 32'(pulse_out[0]), 32'h0);
      chk("c0_any_end",   32'(any_event),    32'h0);
      chk("c0_level_hold",32'(level_out[0]), 32'h1);

      // Falling edge with rising-only mode: level follows, no event
      sig_in = 4'b0000;
      seen = '0;
      for (int c = 0; c < 8; c++) begin step(1); seen |= pulse_out; end
      chk("c0_fall_nopulse", 32'(seen[0]),     32'h0);
      chk("c0_fall_level",   32'(level_out[0]),32'h0);
      chk("c0_fall_cnt",     32'(cnt_out),     32'h1);

      // clr alone, then clr coincident with a qualified event
      clr = 4'b0001; step(1); clr = '0;
      chk("c0_clr_sticky", 32'(sticky[0]), 32'h0);
      chk("c0_clr_cnt",    32'(cnt_out),   32'h0);
      sig_in = 4'b0001;
      step(5);
      clr = 4'b0001;
      step(1);
      chk("c0_clrev_pulse",  32'(pulse_out[0]), 32'h1);
      chk("c0_clrev_sticky", 32'(sticky[0]),    32'h1);
      chk("c0_clrev_cnt",    32'(cnt_out),      32'h1);
      step(1);
      clr = '0;
      chk("c0_clr2_sticky", 32'(sticky[0]), 32'h0);
      chk("c0_clr2_cnt",    32'(cnt_out),   32'h0);

      // Channel 1 two-cycle glitch, mode 11: filtered out
      mode = 8'h0D; cnt_sel = 2'd1;
      sig_in[1] = 1'b1; step(2); sig_in[1] = 1'b0;
      seen = '0;
      for (int c = 0; c < 10; c++) begin step(1); seen |= pulse_out; end
      chk("c1_glitch_pulse",  32'(seen[1]),      32'h0);
      chk("c1_glitch_level",  32'(level_out[1]), 32'h0);
      chk("c1_glitch_sticky", 32'(sticky[1]),    32'h0);
      chk("c1_glitch_cnt",    32'(cnt_out),      32'h0);

      // Channel 2 mode 11: 10-cycle high pulse gives two events 10 apart
      mode = 8'h3D; cnt_sel = 2'd2;
      sig_in[2] = 1'b1;
      npulse = 0; first_c = 0; second_c = 0;
      for (int c = 1; c <= 30; c++) begin
         step(1);
         if (c == 10) sig_in[2] = 1'b0;
         if (pulse_out[2]) begin
            npulse++;
            if (npulse == 1) first_c = c; else second_c = c;
         end
      end
      chk("c2_both_npulse", 32'(npulse),   32'd2);
      chk("c2_both_first",  32'(first_c),  32'd6);
      chk("c2_both_second", 32'(second_c), 32'd16);
      chk("c2_both_cnt",    32'(cnt_out),  32'd2);

      // Channel 2 mode 10: only the fall qualifies
      mode = 8'h2D;
      clr = 4'b0100; step(1); clr = '0;
      sig_in[2] = 1'b1;
      npulse = 0; first_c = 0;
      for (int c = 1; c <= 30; c++) begin
         step(1);
         if (c == 10) sig_in[2] = 1'b0;
         if (pulse_out[2]) begin npulse++; first_c = c; end
      end
      chk("c2_fall_npulse", 32'(npulse),  32'd1);
      chk("c2_fall_at",     32'(first_c), 32'd16);
      chk("c2_fall_cnt",    32'(cnt_out), 32'd1);

      // Channel 3 counter saturation over 260 rising edges
      mode = 8'h6D; cnt_sel = 2'd3;
      for (int k = 1; k <= 260; k++) begin
         sig_in[3] = 1'b1; step(8);
         sig_in[3] = 1'b0; step(8);
         if (k == 100) chk("c3_cnt_100", 32'(cnt_out), 32'd100);
      end
      chk("c3_cnt_sat", 32'(cnt_out), 32'd255);
      sig_in[3] = 1'b1; step(8);
      sig_in[3] = 1'b0; step(8);
      chk("c3_cnt_sat_hold", 32'(cnt_out), 32'd255);

      // Simultaneous events on all channels, mode 11 everywhere
      mode = 8'hFF;
      clr = 4'hF; step(1); clr = '0;
      chk("all_clr_sticky", 32'(sticky), 32'h0);
      exp_lvl = ~sig_in;
      sig_in = exp_lvl;
      step(6);
      chk("all_pulse", 32'(pulse_out), 32'hF);
      chk("all_level", 32'(level_out), 32'(exp_lvl));
      chk("all_sticky",32'(sticky),    32'hF);
      for (int i = 0; i < 4; i++) begin
         cnt_sel = 2'(i); #1;
         chk("all_cnt", 32'(cnt_out), 32'd1);
      end

      // Reset during a pending update, inputs held high through release
      sig_in = 4'hF;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("mid_rst_level",  32'(level_out), 32'h0);
      chk("mid_rst_pulse",  32'(pulse_out), 32'h0);
      chk("mid_rst_sticky", 32'(sticky),    32'h0);
      chk("mid_rst_any",    32'(any_event), 32'h0);
      chk("mid_rst_cnt",    32'(cnt_out),   32'h0);
      seen = '0;
      for (int c = 0; c < 5; c++) begin step(1); seen |= pulse_out; end
      chk("post_rst_early", 32'(seen), 32'h0);
      step(1);
      chk("post_rst_pulse", 32'(pulse_out), 32'hF);
      chk("post_rst_level", 32'(level_out), 32'hF);
      step(1);
      chk("post_rst_once",  32'(pulse_out), 32'h0);
      chk("post_rst_cnt",   32'(cnt_out),   32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
